escalonador_chamadas: RTL and testbench

- Call scheduler and sequencer for the 4-floor elevator movement datapath.
- Latches floor call buttons and selects travel direction with a SCAN (keep-direction) policy.
- Drives motor up/down commands, stops at requested floors, clears served calls and times the door-open interval.
- Sits between the button/floor-sensor inputs and the motor/door actuators; exports its state for display.

---
 rtl/escalonador_chamadas.sv | 104 ++++++++++
 tb/tb_escalonador_chamadas.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_chamadas.sv
// SCAN call scheduler for a 4-floor cab: latches calls, picks direction,
// drives the motor, stops at requested floors and times the door.
module escalonador_chamadas #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] floor,
    input  logic       at_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       dir_up,
    output logic [2:0] state_o
);
    localparam int CW = $clog2(DOOR_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        ARRIVE    = 3'd3,
        DOOR      = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    floor_oh, btn_eff, clr;
    logic          above, below, here, serve_direct;

    assign floor_oh = 4'b0001 << floor;
    assign here     = pending[floor] | btn[floor];

    // A press for the current floor while the door is (or is about to be)
    // open is served on the spot and never becomes a pending call.
    assign serve_direct = (state == DOOR) || (state == IDLE && at_floor);
    assign btn_eff      = serve_direct ? (btn & ~floor_oh) : btn;
    assign clr          = (state == ARRIVE) ? floor_oh : 4'b0000;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i] && i > int'(floor)) above = 1'b1;
            if (pending[i] && i < int'(floor)) below = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 4'b0000;
            dir_up  <= 1'b1;
            cnt     <= '0;
        end else begin
            pending <= (pending | btn_eff) & ~clr;
            case (state)
                IDLE: begin
                    if (at_floor && here) begin
                        state <= DOOR;
                        cnt   <= CNT_MAX;
                    end else if (dir_up && above) begin
                        state <= MOVE_UP;
                    end else if (below) begin
                        state  <= MOVE_DOWN;
                        dir_up <= 1'b0;
                    end else if (above) begin
                        state  <= MOVE_UP;
                        dir_up <= 1'b1;
                    end
                end
                // Top/bottom floor always stops the cab, whatever pending says.
                MOVE_UP:
                    if (at_floor && (pending[floor] || !above || floor == 2'd3))
                        state <= ARRIVE;
                MOVE_DOWN:
                    if (at_floor && (pending[floor] || !below || floor == 2'd0))
                        state <= ARRIVE;
                ARRIVE: begin
                    state <= DOOR;
                    cnt   <= CNT_MAX;
                end
                DOOR: begin
                    if (btn[floor])
                        cnt <= CNT_MAX;
                    else if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign motor_up   = (state == MOVE_UP);
    assign motor_down = (state == MOVE_DOWN);
    assign door_open  = (state == DOOR);
    assign state_o    = state;

endmodule

// File: tb/tb_escalonador_chamadas.sv
// Bench for escalonador_chamadas: directed vector table, hand sequences for
// multi-cycle corners, then random calls against a reference model + cab plant.
module tb_escalonador_chamadas;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] floor;
    logic       at_floor;
    logic       motor_up, motor_down, door_open, dir_up;
    logic [3:0] pending;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    escalonador_chamadas #(.DOOR_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .btn(btn), .floor(floor), .at_floor(at_floor),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .pending(pending), .dir_up(dir_up), .state_o(state_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] b, input logic [1:0] f, input logic a);
        rst = r; btn = b; floor = f; at_floor = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] dut_vec();
        return {state_o, pending, dir_up, motor_up, motor_down, door_open};
    endfunction

    // Reference model: spec rules written over plain ints/bits.
    int       m_st;
    bit [3:0] m_p;
    bit       m_dir;
    int       m_cnt;

    task automatic model_step(input bit r, input bit [3:0] b, input int f, input bit a);
        bit ab = 0, be = 0;
        bit [3:0] np;
        if (r) begin
            m_st = 0; m_p = 0; m_dir = 1; m_cnt = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_p[i] && i > f) ab = 1;
            if (m_p[i] && i < f) be = 1;
        end
        np = m_p | b;
        if (m_st == 4 || (m_st == 0 && a)) np[f] = 0;
        if (m_st == 3) np[f] = 0;
        case (m_st)
            0: if (a && (m_p[f] || b[f])) begin m_st = 4; m_cnt = DC - 1; end
               else if (m_dir && ab) m_st = 1;
               else if (be) begin m_st = 2; m_dir = 0; end
               else if (ab) begin m_st = 1; m_dir = 1; end
            1: if (a && (m_p[f] || !ab || f == 3)) m_st = 3;
            2: if (a && (m_p[f] || !be || f == 0)) m_st = 3;
            3: begin m_st = 4; m_cnt = DC - 1; end
            4: if (b[f]) m_cnt = DC - 1;
               else if (m_cnt == 0) m_st = 0;
               else m_cnt--;
            default: m_st = 0;
        endcase
        m_p = np;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic [1:0] f;
        logic       a;
        logic [10:0] exp; // {state, pending, dir, mu, md, door}
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [1:0] f,
                                input logic a, input logic [2:0] st, input logic [3:0] p,
                                input logic d);
        vec_t v;
        v.r = r; v.b = b; v.f = f; v.a = a;
        v.exp = {st, p, d, st == 3'd1, st == 3'd2, st == 3'd4};
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        int n;
        bit dir_all;
        int pos;

        // Call floor 3 from floor 0, travel, arrive, 8-cycle door, then a
        // direct door open at floor 2.
        tbl[0]  = mk(1, 4'b0000, 0, 1, 0, 4'b0000, 1);
        tbl[1]  = mk(0, 4'b1000, 0, 1, 0, 4'b1000, 1);
        tbl[2]  = mk(0, 4'b0000, 0, 1, 1, 4'b1000, 1);
        tbl[3]  = mk(0, 4'b0000, 1, 0, 1, 4'b1000, 1);
        tbl[4]  = mk(0, 4'b0000, 3, 1, 3, 4'b1000, 1);
        for (int i = 5; i <= 12; i++)
            tbl[i] = mk(0, 4'b0000, 3, 1, 4, 4'b0000, 1);
        tbl[13] = mk(0, 4'b0000, 3, 1, 0, 4'b0000, 1);
        tbl[14] = mk(0, 4'b0100, 2, 1, 4, 4'b0000, 1);
        tbl[15] = mk(0, 4'b0000, 2, 1, 4, 4'b0000, 1);

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].r, tbl[i].b, tbl[i].f, tbl[i].a);
            chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Calls for 2 then 1 while climbing: stop at 1, then 2; a press for
        // the floor being cleared in ARRIVE is dropped, others kept.
        dir_all = 1;
        tick(1, 4'b0000, 0, 1);
        tick(0, 4'b0100, 0, 1); dir_all &= dir_up;
        chk("seq2 pend0", pending, 4'b0100);
        tick(0, 4'b0010, 0, 1); dir_all &= dir_up;
        chk("seq2 go up", state_o, 1);
        tick(0, 4'b0000, 1, 0); dir_all &= dir_up;
        tick(0, 4'b0000, 1, 1); dir_all &= dir_up;
        chk("seq2 stop1", state_o, 3);
        tick(0, 4'b0011, 1, 1); dir_all &= dir_up;
        chk("seq2 clear wins", {state_o, pending}, {3'd4, 4'b0101});
        n = 0;
        while (state_o == 3'd4 && n < 20) begin
            tick(0, 4'b0000, 1, 1); dir_all &= dir_up; n++;
        end
        chk("seq2 door len", n, 8);
        tick(0, 4'b0000, 1, 1); dir_all &= dir_up;
        chk("seq2 continue", state_o, 1);
        tick(0, 4'b0000, 2, 1); dir_all &= dir_up;
        chk("seq2 stop2", state_o, 3);
        tick(0, 4'b0000, 2, 1); dir_all &= dir_up;
        chk("seq2 pend end", pending, 4'b0001);
        chk("seq2 dir held", dir_all, 1);

        // Going up at floor 2 with calls at 3 and 0: serve 3, then reverse.
        tick(1, 4'b0000, 2, 1);
        tick(0, 4'b1001, 2, 1);
        chk("seq3 pend", pending, 4'b1001);
        tick(0, 4'b0000, 2, 1);
        chk("seq3 up", state_o, 1);
        tick(0, 4'b0000, 2, 0);
        tick(0, 4'b0000, 3, 1);
        chk("seq3 arrive3", state_o, 3);
        tick(0, 4'b0000, 3, 1);
        chk("seq3 door pend", {state_o, pending}, {3'd4, 4'b0001});
        n = 0;
        while (state_o != 3'd0 && n < 20) begin
            tick(0, 4'b0000, 3, 1); n++;
        end
        chk("seq3 idle dir", {state_o, dir_up}, {3'd0, 1'b1});
        tick(0, 4'b0000, 3, 1);
        chk("seq3 reverse", dut_vec(), {3'd2, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0});
        tick(0, 4'b0000, 1, 1);
        chk("seq3 pass1", state_o, 2);
        tick(0, 4'b0000, 0, 1);
        chk("seq3 arrive0", state_o, 3);
        tick(0, 4'b0000, 0, 1);
        chk("seq3 done", {state_o, pending}, {3'd4, 4'b0000});

        // Door re-open hold at floor 1.
        tick(1, 4'b0000, 1, 1);
        tick(0, 4'b0010, 1, 1);
        chk("seq4 direct door", {state_o, pending}, {3'd4, 4'b0000});
        for (int i = 0; i < 5; i++) tick(0, 4'b0000, 1, 1);
        tick(0, 4'b0010, 1, 1);
        chk("seq4 reload", {door_open, pending}, {1'b1, 4'b0000});
        n = 0;
        while (door_open && n < 20) begin
            tick(0, 4'b0000, 1, 1); n++;
        end
        chk("seq4 hold len", n, 8);

        // Reset during MOVE_DOWN.
        tick(1, 4'b0000, 2, 1);
        tick(0, 4'b0001, 2, 1);
        tick(0, 4'b1000, 2, 1);
        chk("seq6 moving", dut_vec(), {3'd2, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0});
        tick(0, 4'b0000, 1, 0);
        tick(1, 4'b0000, 1, 0);
        chk("seq6 reset", dut_vec(), {3'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
        tick(0, 4'b0000, 1, 1);
        chk("seq6 no door", dut_vec(), {3'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});

        // Random calls with a cab plant that moves a quarter floor per cycle
        // (with stalls) under the model's motor commands.
        pos = 0;
        model_step(1, 0, 0, 1);
        tick(1, 4'b0000, 0, 1);
        for (int k = 0; k < 3000; k++) begin
            bit        r, a;
            bit [3:0]  b;
            int        f;
            r = ($urandom_range(0, 299) == 0);
            b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            f = pos / 4;
            a = (pos % 4 == 0);
            model_step(r, b, f, a);
            tick(r, b, 2'(f), a);
            chk($sformatf("rand@%0d", k), dut_vec(),
                {m_st[2:0], m_p, m_dir, m_st == 1, m_st == 2, m_st == 4});
            if (m_st == 1 && pos < 12 && $urandom_range(0, 3) != 0) pos++;
            else if (m_st == 2 && pos > 0 && $urandom_range(0, 3) != 0) pos--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
